// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types and codeword layout for the SECDED engine
package hamming_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE} state_t;
  typedef enum logic {M_ENC, M_DEC} mode_t;
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_SEC = 2'b01;
  localparam logic [1:0] ST_DED = 2'b10;
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;
  localparam logic [3:0][15:0] COVER = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};
endpackage

// File: rtl/hamming_secded16.sv
// hamming_secded16: combinational (16,11) extended Hamming encoder and decoder
module hamming_secded16
  import hamming_pkg::*;
(
  input  logic [10:0] data,
  input  logic [15:0] cw,
  output logic [15:0] enc,
  output logic [10:0] dec,
  output logic [1:0]  status
);
  logic [15:0] raw, fixed;
  logic [3:0] syn;
  logic par;
  always_comb begin
    raw = {data[10:4], 1'b0, data[3:1], 1'b0, data[0], 3'b000};
    enc = raw;
    enc[P1] = ^(raw & COVER[0]);
    enc[P2] = ^(raw & COVER[1]);
    enc[P4] = ^(raw & COVER[2]);
    enc[P8] = ^(raw & COVER[3]);
    enc[P0] = ^enc[15:1];
    syn = '0;
    for (int b = 0; b < 4; b++) syn[b] = ^(cw & COVER[b]);
    par = ^cw;
    fixed = par ? cw ^ (16'd1 << syn) : cw;
    status = par ? ST_SEC : (syn != 4'd0 ? ST_DED : ST_OK);
    dec = {fixed[15:9], fixed[7:5], fixed[3]};
  end
endmodule

// File: rtl/hamming_secded_engine.sv
// hamming_secded_engine: memory-to-memory SECDED encode/decode sequencer
module hamming_secded_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG = 15,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              done,
  output logic [7:0]        sec_cnt,
  output logic [7:0]        ded_cnt
);
  state_t state, nxt;
  mode_t mode_r;
  logic [ADDR_W-1:0] src_r, dst_r, k2;
  logic [7:0] k, lo_r, hi_r;
  logic [15:0] enc, res;
  logic [10:0] dec;
  logic [1:0] status;
  logic accept, last;

  hamming_secded16 u_codec (
    .data(dec_in()), .cw({hi_r, lo_r}), .enc(enc), .dec(dec), .status(status)
  );

  function automatic logic [10:0] dec_in();
    return {hi_r[2:0], lo_r};
  endfunction

  assign accept = (state == S_IDLE || state == S_DONE) && start;
  assign last = k == 8'(NUM_MSG - 1);
  assign k2 = ADDR_W'({k, 1'b0});
  assign res = mode_r == M_DEC ? {status, 3'b000, dec} : enc;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_RD_LO : state;
      S_RD_LO: nxt = S_RD_HI;
      S_RD_HI: nxt = S_CAP;
      S_CAP:   nxt = S_WR_LO;
      S_WR_LO: nxt = S_WR_HI;
      S_WR_HI: nxt = last ? S_DONE : S_RD_LO;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done = state == S_DONE;
    mem_we = state == S_WR_LO || state == S_WR_HI;
    mem_addr = state == S_RD_LO ? src_r + k2 :
               state == S_RD_HI ? src_r + k2 + 1'b1 :
               state == S_WR_LO ? dst_r + k2 :
               state == S_WR_HI ? dst_r + k2 + 1'b1 : '0;
    mem_wdata = state == S_WR_LO ? res[7:0] : state == S_WR_HI ? res[15:8] : 8'h00;
  end

  // Synchronous-read memory: the byte addressed in RD_LO arrives during RD_HI, RD_HI's during CAP.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_r <= M_ENC;
      src_r <= '0;
      dst_r <= '0;
      k <= '0;
      lo_r <= '0;
      hi_r <= '0;
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (accept) begin
        mode_r <= mode_t'(mode);
        src_r <= src_base;
        dst_r <= dst_base;
        k <= '0;
        if (mode) begin
          sec_cnt <= '0;
          ded_cnt <= '0;
        end
      end
      if (state == S_RD_HI) lo_r <= mem_rdata;
      if (state == S_CAP) hi_r <= mem_rdata;
      if (state == S_WR_HI) begin
        if (!last) k <= k + 8'd1;
        if (mode_r == M_DEC && status == ST_SEC && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
        if (mode_r == M_DEC && status == ST_DED && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_hamming_secded_engine.sv
// tb_hamming_secded_engine: directed self-checking bench with a synchronous-read byte memory
module tb_hamming_secded_engine;
  logic clk = 0, reset = 1, start = 0, mode = 0;
  logic [7:0] src_base = 0, dst_base = 0, mem_addr, mem_wdata, mem_rdata, sec_cnt, ded_cnt;
  logic mem_we, done;
  logic [7:0] mem [256];
  int n_checks = 0, n_fail = 0;

  hamming_secded_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d, input int pulse, output int cyc);
    bit fin;
    @(negedge clk);
    mode = m; src_base = s; dst_base = d; start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (done) fin = 1;
      else begin
        if (cyc == pulse) begin start = 1; mode = ~mode; end
        @(posedge clk); #1 start = 0;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", mem_we); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata); end
    n_checks++; if ({sec_cnt, ded_cnt} !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %0h/%0h want 0/0", sec_cnt, ded_cnt); end
    reset = 0;
  endtask

  task automatic test_decode_vectors();
    int cyc;
    logic [7:0] a [8] = '{150, 151, 152, 153, 154, 155, 156, 157};
    logic [7:0] e [8] = '{8'hFF, 8'h47, 8'h00, 8'h80, 8'h00, 8'h40, 8'h00, 8'h00};
    for (int i = 100; i < 180; i++) mem[i] = 8'h00;
    mem[100] = 8'hDF; mem[101] = 8'hFF;
    mem[102] = 8'h06; mem[103] = 8'h00;
    mem[104] = 8'h01; mem[105] = 8'h00;
    run(1, 100, 150, -1, cyc);
    n_checks++; if (cyc != 75) begin n_fail++; $display("FAIL dec_latency: got %0d want 75", cyc); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[a[i]] !== e[i]) begin n_fail++; $display("FAIL dec_byte[%0d]: got %0h want %0h", a[i], mem[a[i]], e[i]); end
    end
    n_checks++; if (sec_cnt !== 8'd2) begin n_fail++; $display("FAIL dec_sec_cnt: got %0d want 2", sec_cnt); end
    n_checks++; if (ded_cnt !== 8'd1) begin n_fail++; $display("FAIL dec_ded_cnt: got %0d want 1", ded_cnt); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL done_addr: got %0h want 0", mem_addr); end
  endtask

  task automatic test_encode_bounds();
    int cyc;
    logic [7:0] a [10] = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};
    logic [7:0] e [10] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h17, 8'h81};
    for (int i = 0; i < 30; i++) mem[i] = 8'h00;
    mem[2] = 8'hFF; mem[3] = 8'h07;
    mem[4] = 8'hFF; mem[5] = 8'hFF;
    mem[6] = 8'h01;
    mem[9] = 8'h04;
    run(0, 0, 250, -1, cyc);
    n_checks++; if (cyc != 75) begin n_fail++; $display("FAIL enc_latency: got %0d want 75", cyc); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (mem[a[i]] !== e[i]) begin n_fail++; $display("FAIL enc_byte[%0d]: got %0h want %0h", a[i], mem[a[i]], e[i]); end
    end
    n_checks++; if ({sec_cnt, ded_cnt} !== 16'h0201) begin n_fail++; $display("FAIL enc_cnt_hold: got %0d/%0d want 2/1", sec_cnt, ded_cnt); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    run(0, 0, 60, 5, cyc);
    n_checks++; if (cyc != 75) begin n_fail++; $display("FAIL ign_latency: got %0d want 75", cyc); end
    n_checks++; if ({sec_cnt, ded_cnt} !== 16'h0201) begin n_fail++; $display("FAIL ign_cnt: got %0d/%0d want 2/1", sec_cnt, ded_cnt); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 30; i++) mem[i] = 8'h00;
    for (int i = 100; i < 130; i++) mem[i] = 8'hAA;
    @(negedge clk);
    mode = 0; src_base = 0; dst_base = 100; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_pre_we: got %0h want 1", mem_we); end
    reset = 1;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %0h want 0", mem_we); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0h want 0", done); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL abort_addr: got %0h want 0", mem_addr); end
    n_checks++; if ({sec_cnt, ded_cnt} !== 16'h0000) begin n_fail++; $display("FAIL abort_cnt: got %0d/%0d want 0/0", sec_cnt, ded_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem[103] !== 8'h00) begin n_fail++; $display("FAIL abort_written: got %0h want 00", mem[103]); end
    n_checks++; if (mem[104] !== 8'hAA) begin n_fail++; $display("FAIL abort_unwritten: got %0h want aa", mem[104]); end
    reset = 0;
  endtask

  task automatic test_round_trip();
    int cyc;
    logic [10:0] v [15];
    for (int i = 0; i < 15; i++) begin
      v[i] = 11'($urandom_range(0, 2047));
      mem[2 * i] = v[i][7:0];
      mem[2 * i + 1] = {5'($urandom_range(0, 31)), v[i][10:8]};
    end
    run(0, 0, 30, -1, cyc);
    n_checks++; if (cyc != 75) begin n_fail++; $display("FAIL rt_enc_latency: got %0d want 75", cyc); end
    run(1, 30, 0, -1, cyc);
    n_checks++; if (cyc != 75) begin n_fail++; $display("FAIL rt_dec_latency: got %0d want 75", cyc); end
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if ({mem[2 * i + 1], mem[2 * i]} !== {5'b00000, v[i]})
        begin n_fail++; $display("FAIL rt_msg[%0d]: got %0h want %0h", i, {mem[2 * i + 1], mem[2 * i]}, {5'b00000, v[i]}); end
    end
    n_checks++; if ({sec_cnt, ded_cnt} !== 16'h0000) begin n_fail++; $display("FAIL rt_cnt: got %0d/%0d want 0/0", sec_cnt, ded_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_decode_vectors();
    test_encode_bounds();
    test_start_ignored();
    test_abort();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
